// File: rtl/wb_tick_timer_if.sv
//------------------------------------------------------------------------------
// Module  : wb_tick_timer_if
// Brief   : Wishbone classic bus bundle for the tick timer slave slot.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface wb_tick_timer_if #(
  parameter int DW = 32,
  parameter int AW = 32
);
  logic [AW-1:0] wb_adr_i;
  logic [DW-1:0] wb_dat_i;
  logic [3:0]    wb_sel_i;
  logic          wb_we_i;
  logic          wb_stb_i;
  logic          wb_cyc_i;
  logic [DW-1:0] wb_dat_o;
  logic          wb_ack_o;
  logic          wb_err_o;
  logic          wb_rty_o;

  modport master (
    output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_stb_i, wb_cyc_i,
    input  wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
  );

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_stb_i, wb_cyc_i,
    output wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
  );
endinterface

`default_nettype wire

// File: rtl/wb_tick_timer.sv
//------------------------------------------------------------------------------
// Module  : wb_tick_timer
// Brief   : Wishbone slave tick timer: prescaler, 32-bit down-counter with
//           one-shot/auto-reload, sticky pending flag and level interrupt.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module wb_tick_timer #(
  parameter int DW      = 32,
  parameter int AW      = 32,
  parameter int PRESC_W = 16
) (
  input  wire logic         wb_clk_i,
  input  wire logic         wb_rst_i,
  wb_tick_timer_if.slave    wb,
  output logic              tick_en,
  output logic              irq_o
);

  localparam logic [2:0] c_REG_CTRL   = 3'd0;
  localparam logic [2:0] c_REG_LOAD   = 3'd1;
  localparam logic [2:0] c_REG_COUNT  = 3'd2;
  localparam logic [2:0] c_REG_STATUS = 3'd3;
  localparam logic [2:0] c_REG_PRESC  = 3'd4;

  logic               r_ack;
  logic [DW-1:0]      r_dat;
  logic               r_en;
  logic               r_reload;
  logic               r_ie;
  logic               r_pending;
  logic               r_tick;
  logic [DW-1:0]      r_load;
  logic [DW-1:0]      r_count;
  logic [PRESC_W-1:0] r_presc;
  logic [PRESC_W-1:0] r_p;

  logic               w_req;
  logic               w_wr;
  logic               w_rd;
  logic [2:0]         w_reg;
  logic               w_wr_ctrl;
  logic               w_wr_load;
  logic               w_wr_presc;
  logic               w_clr_pend;
  logic [DW-1:0]      w_ctrl_cur;
  logic [DW-1:0]      w_ctrl_new;
  logic [DW-1:0]      w_load_new;
  logic [DW-1:0]      w_presc_new;
  logic [DW-1:0]      w_rd_data;
  logic               w_step;
  logic               w_expire;
  logic               w_unused_adr;

  function automatic logic [DW-1:0] f_merge(
    input logic [DW-1:0] old_v,
    input logic [DW-1:0] new_v,
    input logic [3:0]    sel
  );
    logic [DW-1:0] res;
    res = old_v;
    for (int i = 0; i < 4; i++) begin
      if (sel[i]) res[8*i +: 8] = new_v[8*i +: 8];
    end
    return res;
  endfunction

  // A request is accepted only while ack is low, giving one wait state and
  // an idle cycle between back-to-back transfers.
  assign w_req = wb.wb_cyc_i & wb.wb_stb_i & ~r_ack;
  assign w_wr  = w_req & wb.wb_we_i;
  assign w_rd  = w_req & ~wb.wb_we_i;
  assign w_reg = wb.wb_adr_i[4:2];

  assign w_unused_adr = ^{wb.wb_adr_i[AW-1:5], wb.wb_adr_i[1:0]};

  assign w_wr_ctrl  = w_wr && (w_reg == c_REG_CTRL);
  assign w_wr_load  = w_wr && (w_reg == c_REG_LOAD);
  assign w_wr_presc = w_wr && (w_reg == c_REG_PRESC);
  assign w_clr_pend = w_wr && (w_reg == c_REG_STATUS) && wb.wb_sel_i[0] && wb.wb_dat_i[0];

  assign w_ctrl_cur  = {{(DW-3){1'b0}}, r_ie, r_reload, r_en};
  assign w_ctrl_new  = f_merge(w_ctrl_cur, wb.wb_dat_i, wb.wb_sel_i);
  assign w_load_new  = f_merge(r_load, wb.wb_dat_i, wb.wb_sel_i);
  assign w_presc_new = f_merge(DW'(r_presc), wb.wb_dat_i, wb.wb_sel_i);

  // A LOAD write in the same cycle takes precedence over any step outcome.
  assign w_step   = r_en && (r_p == r_presc);
  assign w_expire = w_step && (r_count == '0) && !w_wr_load;

  always_comb begin
    w_rd_data = '0;
    case (w_reg)
      c_REG_CTRL:   w_rd_data = w_ctrl_cur;
      c_REG_LOAD:   w_rd_data = r_load;
      c_REG_COUNT:  w_rd_data = r_count;
      c_REG_STATUS: w_rd_data = {{(DW-1){1'b0}}, r_pending};
      c_REG_PRESC:  w_rd_data = DW'(r_presc);
      default:      w_rd_data = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_ack     <= 1'b0;
      r_dat     <= '0;
      r_en      <= 1'b0;
      r_reload  <= 1'b0;
      r_ie      <= 1'b0;
      r_pending <= 1'b0;
      r_tick    <= 1'b0;
      r_load    <= '0;
      r_count   <= '0;
      r_presc   <= '0;
      r_p       <= '0;
    end else begin
      r_ack  <= w_req;
      r_tick <= w_expire;

      if (w_rd) r_dat <= w_rd_data;

      if (!r_en || w_step) r_p <= '0;
      else                 r_p <= r_p + 1'b1;

      if (w_wr_ctrl) begin
        r_en     <= w_ctrl_new[0];
        r_reload <= w_ctrl_new[1];
        r_ie     <= w_ctrl_new[2];
      end
      // One-shot expiry disables the timer even if CTRL is written meanwhile.
      if (w_expire && !r_reload) r_en <= 1'b0;

      if (w_wr_load) begin
        r_load  <= w_load_new;
        r_count <= w_load_new;
      end else if (w_step) begin
        if (r_count != '0) r_count <= r_count - 1'b1;
        else if (r_reload) r_count <= r_load;
      end

      if (w_expire)        r_pending <= 1'b1;
      else if (w_clr_pend) r_pending <= 1'b0;

      if (w_wr_presc) r_presc <= w_presc_new[PRESC_W-1:0];
    end
  end

  assign wb.wb_ack_o = r_ack;
  assign wb.wb_dat_o = r_dat;
  assign wb.wb_err_o = 1'b0;
  assign wb.wb_rty_o = 1'b0;
  assign tick_en     = r_tick;
  assign irq_o       = r_pending & r_ie;

endmodule

`default_nettype wire

// File: tb/tb_wb_tick_timer.sv
//------------------------------------------------------------------------------
// Module  : tb_wb_tick_timer
// Brief   : Scoreboard bench for wb_tick_timer with directed bus vectors.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_wb_tick_timer;

  typedef struct {
    bit          rd;
    logic [31:0] d;
    logic [2:0]  a;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tick;
  logic irq;

  int   cyc_cnt = 0;
  int   n_chk   = 0;
  int   n_fail  = 0;
  exp_t exp_q[$];
  int   tick_q[$];
  exp_t mon_e;

  wb_tick_timer_if #(.DW(32), .AW(32)) u_bus ();

  wb_tick_timer #(.DW(32), .AW(32), .PRESC_W(16)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .wb       (u_bus.slave),
    .tick_en  (tick),
    .irq_o    (irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc_cnt);
    end
  endtask

  // Monitor: pops the expected response whenever the DUT acks or ticks.
  always @(negedge clk) begin
    if (u_bus.wb_ack_o) begin
      if (exp_q.size() == 0) check("unexpected ack", u_bus.wb_ack_o, 1'b0);
      else begin
        mon_e = exp_q.pop_front();
        if (mon_e.rd) check($sformatf("read reg %0d", mon_e.a), u_bus.wb_dat_o, mon_e.d);
      end
    end
    if (tick) begin
      if (tick_q.size() == 0) check("unexpected tick_en", tick, 1'b0);
      else                    check("tick_en cycle", cyc_cnt, tick_q.pop_front());
    end
  end

  task automatic wait_cycle(input int target);
    while (cyc_cnt < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus(input bit wr, input logic [4:0] addr, input logic [31:0] data,
                     input logic [3:0] sel, input logic [31:0] exp_rd, output int edge_o);
    exp_t e;
    int   n;
    e.rd = !wr;
    e.d  = exp_rd;
    e.a  = addr[4:2];
    exp_q.push_back(e);
    u_bus.wb_adr_i = {27'd0, addr};
    u_bus.wb_dat_i = data;
    u_bus.wb_sel_i = sel;
    u_bus.wb_we_i  = wr;
    u_bus.wb_cyc_i = 1'b1;
    u_bus.wb_stb_i = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!u_bus.wb_ack_o && n < 8);
    edge_o = cyc_cnt;
    check("ack latency", n, 1);
    u_bus.wb_cyc_i = 1'b0;
    u_bus.wb_stb_i = 1'b0;
    u_bus.wb_we_i  = 1'b0;
    @(posedge clk);
    #1;
    check("ack width", u_bus.wb_ack_o, 1'b0);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d, output int edge_o);
    bus(1'b1, a, d, 4'hF, 32'h0, edge_o);
  endtask

  task automatic rd(input logic [4:0] a, input logic [31:0] exp);
    int dummy;
    bus(1'b0, a, 32'h0, 4'h0, exp, dummy);
  endtask

  initial begin
    int e;
    int e2;
    bit bad;
    u_bus.wb_adr_i = '0;
    u_bus.wb_dat_i = '0;
    u_bus.wb_sel_i = '0;
    u_bus.wb_we_i  = 1'b0;
    u_bus.wb_cyc_i = 1'b0;
    u_bus.wb_stb_i = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset ack", u_bus.wb_ack_o, 1'b0);
    check("reset dat", u_bus.wb_dat_o, 32'h0);
    check("reset tick", tick, 1'b0);
    check("reset irq", irq, 1'b0);
    rst = 1'b0;
    for (int a = 0; a < 8; a++) rd(5'(a * 4), 32'h0);

    // Auto-reload: (4+1)*(3+1) = 20 cycles per expiry
    wr(5'h10, 32'd3, e);
    wr(5'h04, 32'd4, e);
    wr(5'h00, 32'h3, e);
    for (int k = 1; k <= 5; k++) tick_q.push_back(e + 20 * k);
    wait_cycle(e + 102);
    wr(5'h00, 32'h0, e);
    check("periodic ticks consumed", tick_q.size(), 0);
    wr(5'h0C, 32'h1, e);
    rd(5'h0C, 32'h0);

    // One-shot with interrupt enable
    wr(5'h10, 32'd0, e);
    wr(5'h04, 32'd2, e);
    wr(5'h00, 32'h5, e);
    tick_q.push_back(e + 3);
    wait_cycle(e + 50);
    check("one-shot irq set", irq, 1'b1);
    check("one-shot ticks consumed", tick_q.size(), 0);
    rd(5'h00, 32'h4);
    rd(5'h08, 32'h0);
    rd(5'h0C, 32'h1);
    wr(5'h0C, 32'h1, e);
    check("irq after clear", irq, 1'b0);

    // STATUS clear on the exact expiry edge: set wins
    wr(5'h04, 32'd2, e);
    wr(5'h00, 32'h1, e);
    tick_q.push_back(e + 3);
    wait_cycle(e + 2);
    wr(5'h0C, 32'h1, e2);
    check("clear lands on expiry edge", e2, e + 3);
    rd(5'h0C, 32'h1);
    check("irq with ie=0", irq, 1'b0);
    wr(5'h0C, 32'h1, e);
    rd(5'h0C, 32'h0);

    // Byte-lane write
    bus(1'b1, 5'h04, 32'hFFFF_FFFF, 4'hF, 32'h0, e);
    bus(1'b1, 5'h04, 32'h0000_0012, 4'h1, 32'h0, e);
    rd(5'h04, 32'hFFFF_FF12);
    rd(5'h08, 32'hFFFF_FF12);

    // Reset during count with a read in flight
    wr(5'h04, 32'd20, e);
    wr(5'h00, 32'h5, e);
    wait_cycle(e + 13);
    u_bus.wb_adr_i = 32'h8;
    u_bus.wb_we_i  = 1'b0;
    u_bus.wb_cyc_i = 1'b1;
    u_bus.wb_stb_i = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("no ack under reset", u_bus.wb_ack_o, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    u_bus.wb_cyc_i = 1'b0;
    u_bus.wb_stb_i = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (tick !== 1'b0 || irq !== 1'b0 || u_bus.wb_ack_o !== 1'b0) bad = 1'b1;
    end
    check("quiet after reset", bad, 1'b0);
    for (int a = 0; a < 8; a++) rd(5'(a * 4), 32'h0);

    check("response queue drained", exp_q.size(), 0);
    check("tick queue drained", tick_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/wb_tick_timer.md
Name: wb_tick_timer

Overview:
- Wishbone classic slave timer that generates the `tick_en` pulse consumed by the CPU and the interrupt vector (bit 3 of `interrupt`). That bit is currently tied to 0.
- It occupies one slave slot on the intercon, with 32-bit data and address.
- It provides a programmable prescaler, a 32-bit down-counter with one-shot or auto-reload mode, a sticky pending flag and a level interrupt output.

Parameters:
- DW, 32, Wishbone data width; fixed at 32.
- AW, 32, Wishbone address width; only adr[4:2] is decoded.
- PRESC_W, 16, prescaler width in bits.

Ports:
- wb_clk_i  in  1  clock; the single clock domain.
- wb_rst_i  in  1  reset; synchronous, active-high.
- wb_adr_i  in  AW  byte address; adr[4:2] selects the register.
- wb_dat_i  in  DW  write data.
- wb_sel_i  in  4  byte enables for writes.
- wb_we_i  in  1  write enable.
- wb_stb_i  in  1  strobe.
- wb_cyc_i  in  1  cycle.
- wb_dat_o  out  DW  read data, registered.
- wb_ack_o  out  1  acknowledge.
- wb_err_o  out  1  constant 0.
- wb_rty_o  out  1  constant 0.
- tick_en  out  1  one-cycle pulse on each expiry.
- irq_o  out  1  level interrupt, equal to pending AND ie.

Behaviour:
- Clock and reset: single clock `wb_clk_i`. Reset `wb_rst_i` is synchronous and active-high.
- Values on reset: all registers, prescaler counter, `wb_ack_o`, `wb_dat_o`, `tick_en` and `irq_o` go to 0.
- Reset asserted mid-count or mid-transfer aborts the operation. There is no ack in the cycle after reset.
- Register map (adr[4:2]):
  - 0x00 CTRL: bit0 en, bit1 reload (auto-reload), bit2 ie; other bits read 0.
  - 0x04 LOAD: 32-bit reload value. Writing LOAD also copies the new value into COUNT in the same edge.
  - 0x08 COUNT: read-only; writes are acked and ignored.
  - 0x0C STATUS: bit0 pending; write-1-to-clear.
  - 0x10 PRESC: [PRESC_W-1:0] prescale value.
  - 0x14–0x1C: read 0; writes are ignored and acked.
- Bus handshake:
  - When cyc & stb & !ack, `wb_ack_o` is set to 1 at the next edge, giving one wait state.
  - `wb_ack_o` is held for exactly one cycle, then 0. Back-to-back requests are acked every other cycle.
  - A write commits on the same edge that raises ack. The wb_sel_i byte lanes mask the write per byte.
  - Read data is loaded into `wb_dat_o` on the ack edge. `wb_dat_o` holds its value otherwise.
  - If stb or cyc drops before ack, no ack is issued and nothing is written.
- Prescaler:
  - When en=1, the prescaler counter p increments each cycle.
  - When p==PRESC, p returns to 0 and a step occurs. A step therefore happens every PRESC+1 cycles.
  - When en=0, p is forced to 0 and COUNT holds its value.
- Step:
  - If COUNT != 0, COUNT decrements by 1.
  - If COUNT == 0, the timer expires:
    - `tick_en` = 1 for the next cycle.
    - pending is set to 1.
    - If reload=1, COUNT is loaded from LOAD.
    - If reload=0, COUNT stays 0 and en is cleared (one-shot).
  - Expiry period = (LOAD+1)*(PRESC+1) cycles.
- Timing after enable:
  - The first expiry occurs (COUNT+1)*(PRESC+1) cycles after the edge that sets en.
  - `tick_en` is registered, so it is high in the cycle following the expiry step.
- Simultaneous events:
  - Expiry and a STATUS clear write in the same cycle: pending remains 1 (set wins).
  - LOAD write and a step in the same cycle: COUNT takes the written LOAD value; no decrement and no expiry in that cycle. The prescaler is unaffected.
  - CTRL write that clears en in the same cycle as an expiry: the expiry is still reported (`tick_en` and pending both fire) and en ends at 0.
- Arithmetic: COUNT never wraps below 0; it is checked against 0 before decrementing. LOAD=0 with reload=1 expires every PRESC+1 cycles.
- `irq_o` is combinational from the pending and ie flops.

Test Plan:
- Reset, then read all 8 addresses → each returns 0. Each ack is high for exactly 1 cycle, one cycle after stb rises.
- PRESC=3, LOAD=4, CTRL=0x3 (en, reload) → `tick_en` pulses every 20 cycles. The first pulse is 20 cycles after the CTRL write edge (+1 for register delay). Run 5 periods.
- One-shot: PRESC=0, LOAD=2, CTRL=0x5 (en, ie) → single `tick_en` 3 cycles after enable. `irq_o`=1, CTRL reads 0x4. No further pulses over 50 cycles. Write STATUS=1 → `irq_o`=0.
- Write STATUS=1 on the exact cycle of expiry → STATUS reads 1 afterwards. A second clear → 0.
- Byte-lane write: LOAD=0xFFFFFFFF, then write 0x00000012 with sel=4'b0001 → LOAD reads 0xFFFFFF12 and COUNT equals 0xFFFFFF12.
- Assert reset while COUNT=7 and a read is pending → no ack, all registers 0, `tick_en` and `irq_o` stay 0 after release.
